// File: rtl/ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared definitions for the ctrl_fsm control unit: opcode
//            constants, ALU mode codes, FSM state encoding, instruction
//            field positions and small decode helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Instruction field bit positions
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;

  // Opcodes (all 16 codes are legal)
  localparam logic [3:0] OP_LD  = 4'b0000;
  localparam logic [3:0] OP_ST  = 4'b0001;
  localparam logic [3:0] OP_MI  = 4'b0010;
  localparam logic [3:0] OP_MR  = 4'b0011;
  localparam logic [3:0] OP_SUM = 4'b0100;
  localparam logic [3:0] OP_SB  = 4'b0101;
  localparam logic [3:0] OP_ANR = 4'b0110;
  localparam logic [3:0] OP_CM  = 4'b0111;
  localparam logic [3:0] OP_ORR = 4'b1000;
  localparam logic [3:0] OP_ORI = 4'b1001;
  localparam logic [3:0] OP_XRR = 4'b1010;
  localparam logic [3:0] OP_XRI = 4'b1011;
  localparam logic [3:0] OP_SMI = 4'b1100;
  localparam logic [3:0] OP_SBI = 4'b1101;
  localparam logic [3:0] OP_ANI = 4'b1110;
  localparam logic [3:0] OP_CMI = 4'b1111;

  // ALU mode codes
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_CMP  = 3'b110;

  // Control state encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Opcodes whose ALU operand B is the 2-bit immediate in instr[1:0]
  function automatic logic is_imm2_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_MI, OP_ORI, OP_XRI, OP_SMI, OP_SBI, OP_ANI, OP_CMI: r = 1'b1;
      default:                                               r = 1'b0;
    endcase
    return r;
  endfunction

  // Compare opcodes finish in EXEC and pulse the flags instead of writing back
  function automatic logic is_cmp_op(input logic [3:0] op);
    return (op == OP_CM) || (op == OP_CMI);
  endfunction

  function automatic logic [2:0] alu_mode_of(input logic [3:0] op);
    logic [2:0] m;
    case (op)
      OP_SUM, OP_SMI: m = ALU_ADD;
      OP_SB,  OP_SBI: m = ALU_SUB;
      OP_ANR, OP_ANI: m = ALU_AND;
      OP_ORR, OP_ORI: m = ALU_OR;
      OP_XRR, OP_XRI: m = ALU_XOR;
      OP_CM,  OP_CMI: m = ALU_CMP;
      default:        m = ALU_PASS;   // LD, ST, MI, MR
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_fsm_if
// Purpose  : Bundle of the instruction handshake, memory acknowledge and all
//            datapath control strobes of ctrl_fsm.
// Modports : master - instruction source / datapath side (drives instr,
//                     instr_valid, mem_ready; observes control outputs)
//            slave  - the control unit itself
// Revision : 1.0 - initial release
// ============================================================================
interface ctrl_fsm_if #(
  parameter int DATA_W = 8
);
  logic [7:0]        instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              mem_ready;
  logic              alu_enable;
  logic [2:0]        alu_mode;
  logic              direct_imm;
  logic [DATA_W-1:0] imm_out;
  logic [1:0]        rs_sel;
  logic [1:0]        rd_sel;
  logic              reg_enable;
  logic              reg_rw;
  logic              mem_enable;
  logic              mem_rw;
  logic              flags_we;
  logic              busy;

  modport master (
    output instr, instr_valid, mem_ready,
    input  instr_ready, alu_enable, alu_mode, direct_imm, imm_out, rs_sel,
           rd_sel, reg_enable, reg_rw, mem_enable, mem_rw, flags_we, busy
  );

  modport slave (
    input  instr, instr_valid, mem_ready,
    output instr_ready, alu_enable, alu_mode, direct_imm, imm_out, rs_sel,
           rd_sel, reg_enable, reg_rw, mem_enable, mem_rw, flags_we, busy
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_fsm_imm_sext.sv
`default_nettype none
// ============================================================================
// Module   : imm_sext
// Purpose  : Combinational immediate generator. LD sign-extends the whole low
//            nibble, immediate ALU ops sign-extend instr[1:0], every other
//            opcode yields zero.
// Ports    : opcode_i [3:0]      instruction opcode
//            nibble_i [3:0]      instruction low nibble
//            imm_o    [DATA_W-1:0] sign-extended immediate
// Revision : 1.0 - initial release
// ============================================================================
module imm_sext
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        opcode_i,
  input  logic [3:0]        nibble_i,
  output logic [DATA_W-1:0] imm_o
);

  always_comb begin
    imm_o = '0;
    if (opcode_i == OP_LD) begin
      imm_o = DATA_W'($signed(nibble_i));
    end else if (is_imm2_op(opcode_i)) begin
      imm_o = DATA_W'($signed(nibble_i[1:0]));
    end
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_fsm
// Purpose  : Multi-cycle control unit. Accepts one instruction per
//            valid/ready handshake, decodes it and sequences
//            DECODE -> EXEC -> WB (ALU ops), DECODE -> EXEC (compares) or
//            DECODE -> MEM (store), driving registered datapath strobes.
// Params   : DATA_W  immediate width, 4..32
//            ALU_LAT cycles alu_enable is held in EXEC, 1..4
// Ports    : clk, rst (sync, active high)
//            bus : ctrl_fsm_if.slave - handshake, mem_ready, all controls
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  ctrl_fsm_if.slave  bus
);

  localparam int CNT_W = 2;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q;

  logic               ready_q, busy_q;
  logic               alu_en_q, flags_we_q, reg_en_q, mem_en_q;
  logic [2:0]         alu_mode_q;
  logic               direct_imm_q;
  logic [DATA_W-1:0]  imm_q;
  logic [1:0]         rs_q, rd_q;

  // Combinational decode of the incoming instruction; captured at handshake
  // so the fields are already visible during DECODE.
  logic [3:0]         in_op;
  logic               in_is_imm;
  logic [1:0]         dec_rs, dec_rd;
  logic [DATA_W-1:0]  dec_imm;
  logic               capture;

  assign in_op     = bus.instr[OPC_MSB:OPC_LSB];
  // LD routes its immediate through the ALU PASS path as operand B.
  assign in_is_imm = (in_op == OP_LD) || is_imm2_op(in_op);
  assign dec_rd    = (in_op == OP_LD) ? 2'b00 : bus.instr[RD_MSB:RD_LSB];
  assign dec_rs    = in_is_imm ? 2'b00 : bus.instr[RS_MSB:RS_LSB];
  assign capture   = (state_q == ST_IDLE) && bus.instr_valid && ready_q;

  imm_sext #(.DATA_W(DATA_W)) u_imm_sext (
    .opcode_i (in_op),
    .nibble_i (bus.instr[3:0]),
    .imm_o    (dec_imm)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = (op_q == OP_ST) ? ST_MEM : ST_EXEC;
        cnt_d   = CNT_W'(ALU_LAT - 1);
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d = is_cmp_op(op_q) ? ST_IDLE : ST_WB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_MEM: begin
        if (bus.mem_ready) state_d = ST_IDLE;
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      alu_en_q     <= 1'b0;
      flags_we_q   <= 1'b0;
      reg_en_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      alu_mode_q   <= '0;
      direct_imm_q <= 1'b0;
      imm_q        <= '0;
      rs_q         <= '0;
      rd_q         <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= (state_d == ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
      alu_en_q   <= (state_d == ST_EXEC);
      // Last EXEC cycle is the one entered with the counter at zero.
      flags_we_q <= (state_d == ST_EXEC) && (cnt_d == '0) && is_cmp_op(op_q);
      reg_en_q   <= (state_d == ST_WB);
      mem_en_q   <= (state_d == ST_MEM);
      if (capture) begin
        op_q         <= in_op;
        alu_mode_q   <= alu_mode_of(in_op);
        direct_imm_q <= in_is_imm;
        imm_q        <= dec_imm;
        rs_q         <= dec_rs;
        rd_q         <= dec_rd;
      end
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.alu_enable  = alu_en_q;
  assign bus.flags_we    = flags_we_q;
  assign bus.reg_enable  = reg_en_q;
  assign bus.reg_rw      = reg_en_q;
  assign bus.mem_enable  = mem_en_q;
  assign bus.mem_rw      = mem_en_q;
  assign bus.alu_mode    = alu_mode_q;
  assign bus.direct_imm  = direct_imm_q;
  assign bus.imm_out     = imm_q;
  assign bus.rs_sel      = rs_q;
  assign bus.rd_sel      = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_fsm
// Purpose  : Scoreboard bench for ctrl_fsm. u0: DATA_W=8, ALU_LAT=1;
//            u1: DATA_W=16, ALU_LAT=3. Each busy cycle of a DUT is compared
//            against the next expected snapshot in that DUT's queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_fsm;

  typedef struct packed {
    logic [5:0]  stb;   // {alu_en, flags_we, reg_en, reg_rw, mem_en, mem_rw}
    logic [2:0]  mode;
    logic        di;
    logic [1:0]  rs;
    logic [1:0]  rd;
    logic [15:0] imm;
  } exp_t;

  localparam logic [5:0] S_ALU = 6'b100000;
  localparam logic [5:0] S_FLG = 6'b010000;
  localparam logic [5:0] S_WB  = 6'b001100;
  localparam logic [5:0] S_MEM = 6'b000011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  ctrl_fsm_if #(.DATA_W(8))  b0();
  ctrl_fsm_if #(.DATA_W(16)) b1();

  ctrl_fsm #(.DATA_W(8),  .ALU_LAT(1)) u0 (.clk(clk), .rst(rst0), .bus(b0));
  ctrl_fsm #(.DATA_W(16), .ALU_LAT(3)) u1 (.clk(clk), .rst(rst1), .bus(b1));

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic [2:0] mode, input logic di,
                              input logic [1:0] rs, input logic [1:0] rd,
                              input logic [15:0] imm);
    exp_t e;
    e.stb = 6'b0; e.mode = mode; e.di = di; e.rs = rs; e.rd = rd; e.imm = imm;
    return e;
  endfunction

  function automatic exp_t snap(input int dut);
    exp_t a;
    if (dut == 0) begin
      a.stb  = {b0.alu_enable, b0.flags_we, b0.reg_enable, b0.reg_rw,
                b0.mem_enable, b0.mem_rw};
      a.mode = b0.alu_mode; a.di = b0.direct_imm;
      a.rs = b0.rs_sel; a.rd = b0.rd_sel; a.imm = {8'h00, b0.imm_out};
    end else begin
      a.stb  = {b1.alu_enable, b1.flags_we, b1.reg_enable, b1.reg_rw,
                b1.mem_enable, b1.mem_rw};
      a.mode = b1.alu_mode; a.di = b1.direct_imm;
      a.rs = b1.rs_sel; a.rd = b1.rd_sel; a.imm = b1.imm_out;
    end
    return a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input int dut, input exp_t e);
    if (dut == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // DECODE, ALU_LAT x EXEC, then WB unless it is a compare
  task automatic push_alu(input int dut, input exp_t f, input int lat, input bit cmp);
    exp_t e;
    push(dut, f);
    for (int i = 0; i < lat; i++) begin
      e = f;
      e.stb = S_ALU | ((cmp && i == lat - 1) ? S_FLG : 6'b0);
      push(dut, e);
    end
    if (!cmp) begin
      e = f; e.stb = S_WB; push(dut, e);
    end
  endtask

  task automatic push_st(input int dut, input exp_t f, input int mem_cycles);
    exp_t e;
    push(dut, f);
    for (int i = 0; i < mem_cycles; i++) begin
      e = f; e.stb = S_MEM; push(dut, e);
    end
  endtask

  // Called at a negedge in a ready cycle; returns just after the capture edge.
  task automatic issue(input int dut, input logic [7:0] ins);
    if (dut == 0) begin b0.instr = ins; b0.instr_valid = 1'b1; end
    else          begin b1.instr = ins; b1.instr_valid = 1'b1; end
    @(posedge clk); #1;
    if (dut == 0) b0.instr_valid = 1'b0; else b1.instr_valid = 1'b0;
  endtask

  // Counts cycles after the capture edge until instr_ready is seen again.
  task automatic wait_ready(input int dut, input int exp_n, input string name);
    int n;
    logic r;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      r = (dut == 0) ? b0.instr_ready : b1.instr_ready;
    end while (r !== 1'b1 && n < 100);
    chk(name, 64'(n), 64'(exp_n));
  endtask

  // Monitor: every busy cycle must match the next queued expectation.
  initial begin
    exp_t a, e;
    forever begin
      @(negedge clk);
      if (b0.busy === 1'b1) begin
        a = snap(0);
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon0 unexpected busy cycle actual=%h expected=none", a);
        end else begin
          e = q0.pop_front();
          chk("mon0", 64'(a), 64'(e));
        end
      end
      if (b1.busy === 1'b1) begin
        a = snap(1);
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon1 unexpected busy cycle actual=%h expected=none", a);
        end else begin
          e = q1.pop_front();
          chk("mon1", 64'(a), 64'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  logic [7:0] stream [8];

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    b0.instr = '0; b0.instr_valid = 1'b0; b0.mem_ready = 1'b0;
    b1.instr = '0; b1.instr_valid = 1'b0; b1.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst0_outputs", {62'(snap(0)), b0.instr_ready, b0.busy}, 64'h0);
    chk("rst1_outputs", {62'(snap(1)), b1.instr_ready, b1.busy}, 64'h0);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("rdy0_after_rst", 64'(b0.instr_ready), 64'h1);
    chk("rdy1_after_rst", 64'(b1.instr_ready), 64'h1);

    // ---------------- u0: DATA_W=8, ALU_LAT=1 ----------------
    // SMI: rd=01, imm=sext(10)=FE, ADD
    push_alu(0, mk(3'b001, 1'b1, 2'b00, 2'b01, 16'h00FE), 1, 1'b0);
    issue(0, 8'b1100_0110);
    wait_ready(0, 4, "smi_latency");

    // XRR: rd=11, rs=10, XOR, register operand
    push_alu(0, mk(3'b101, 1'b0, 2'b10, 2'b11, 16'h0000), 1, 1'b0);
    issue(0, 8'b1010_1110);
    wait_ready(0, 4, "xrr_latency");

    // CMI: imm=FF, CMP, flags pulse in EXEC, no writeback
    push_alu(0, mk(3'b110, 1'b1, 2'b00, 2'b00, 16'h00FF), 1, 1'b1);
    issue(0, 8'b1111_0011);
    wait_ready(0, 3, "cmi_latency");

    // ST with mem_ready low for three MEM cycles, then high
    push_st(0, mk(3'b000, 1'b0, 2'b01, 2'b10, 16'h0000), 4);
    issue(0, 8'b0001_1001);
    fork
      begin
        repeat (4) @(posedge clk);
        #1 b0.mem_ready = 1'b1;
        @(posedge clk);
        #1 b0.mem_ready = 1'b0;
      end
    join_none
    wait_ready(0, 6, "st_slow_latency");

    // ST with mem_ready already high (ignored during DECODE)
    b0.mem_ready = 1'b1;
    push_st(0, mk(3'b000, 1'b0, 2'b10, 2'b01, 16'h0000), 1);
    issue(0, 8'b0001_0110);
    wait_ready(0, 3, "st_fast_latency");
    b0.mem_ready = 1'b0;

    // Back-to-back offers: only SUM (cycle 0) and ORI (cycle 4) are captured
    stream[0] = 8'b0100_0110;  // SUM rd=01 rs=10
    stream[1] = 8'b0111_0000;  // CM
    stream[2] = 8'b0000_1111;  // LD
    stream[3] = 8'b0001_0101;  // ST
    stream[4] = 8'b1001_0111;  // ORI rd=01 imm=FF
    stream[5] = 8'b1010_0101;  // XRR
    stream[6] = 8'b0010_1101;  // MI
    stream[7] = 8'b0101_1010;  // SB
    push_alu(0, mk(3'b001, 1'b0, 2'b10, 2'b01, 16'h0000), 1, 1'b0);
    push_alu(0, mk(3'b100, 1'b1, 2'b00, 2'b01, 16'h00FF), 1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      b0.instr = stream[k];
      b0.instr_valid = 1'b1;
      @(posedge clk); #1;
    end
    b0.instr_valid = 1'b0;
    @(negedge clk);
    chk("stream_ready_after", 64'(b0.instr_ready), 64'h1);
    repeat (3) @(negedge clk);
    chk("q0_drained", 64'(q0.size()), 64'h0);

    // ---------------- u1: DATA_W=16, ALU_LAT=3 ----------------
    push_alu(1, mk(3'b000, 1'b1, 2'b00, 2'b00, 16'hFFFA), 3, 1'b0);
    issue(1, 8'b0000_1010);
    wait_ready(1, 6, "ld_neg_latency");

    push_alu(1, mk(3'b000, 1'b1, 2'b00, 2'b00, 16'h0005), 3, 1'b0);
    issue(1, 8'b0000_0101);
    wait_ready(1, 6, "ld_pos_latency");

    push_alu(1, mk(3'b000, 1'b1, 2'b00, 2'b11, 16'hFFFE), 3, 1'b0);
    issue(1, 8'b0010_1110);
    wait_ready(1, 6, "mi_latency");

    // ANR, reset in the second EXEC cycle
    begin
      exp_t f, e;
      f = mk(3'b011, 1'b0, 2'b01, 2'b11, 16'h0000);
      push(1, f);
      e = f; e.stb = S_ALU;
      push(1, e);
      push(1, e);
    end
    issue(1, 8'b0110_1101);          // now in DECODE
    @(posedge clk); #1;              // first EXEC
    @(posedge clk); #1;              // second EXEC
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    @(negedge clk);
    chk("rst_mid_exec_outputs", {62'(snap(1)), b1.instr_ready, b1.busy}, 64'h0);
    @(negedge clk);
    chk("rdy_after_mid_rst", 64'(b1.instr_ready), 64'h1);
    chk("q1_after_mid_rst", 64'(q1.size()), 64'h0);

    // Recovery after reset: SBI imm=0001, SUB
    push_alu(1, mk(3'b010, 1'b1, 2'b00, 2'b00, 16'h0001), 3, 1'b0);
    issue(1, 8'b1101_0001);
    wait_ready(1, 6, "sbi_latency");
    repeat (2) @(negedge clk);
    chk("q1_drained", 64'(q1.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
